// File: rtl/even_stream_ctrl_pkg.sv
// Shared constants for the even-stream controller: FSM state codes and
// default datapath/counter widths.
package even_stream_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/even_stream_ctrl_even_check.sv
// Stateless even-check datapath: a number is even when its LSB is clear.
module even_check
  import even_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] num,
  output logic             is_even
);

  // Masking the whole word keeps every input bit referenced; the result
  // depends only on bit 0.
  assign is_even = ~|(num & WIDTH'(1));

endmodule

// File: rtl/even_stream_ctrl.sv
// Block sequencer: accepts `len` numbers over valid/ready, tallies even and
// odd values through even_check, and pulses done with the final totals.
module even_stream_ctrl
  import even_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt
);

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             is_even;
  logic             accept;

  even_check #(
    .WIDTH (WIDTH)
  ) u_even_check (
    .num     (in_data),
    .is_even (is_even)
  );

  // Handshake and status outputs are decoded purely from the current state,
  // so in_ready drops in the same cycle the FSM reaches DONE.
  always_comb begin
    in_ready = (state == ST_RUN);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    accept   = in_ready & in_valid;
  end

  // FSM, remaining-beat counter and result counters. Counters are cleared
  // only when a new block starts, so totals remain readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      even_cnt  <= '0;
      odd_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            even_cnt  <= '0;
            odd_cnt   <= '0;
            remaining <= len;
            state     <= (len != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (is_even) begin
              even_cnt <= even_cnt + CNT_W'(1);
            end else begin
              odd_cnt  <= odd_cnt + CNT_W'(1);
            end
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_even_stream_ctrl.sv
// Directed self-checking bench for even_stream_ctrl.
module tb_even_stream_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] even_cnt;
  logic [CNT_W-1:0] odd_cnt;

  int compared;
  int mismatched;

  even_stream_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .even_cnt (even_cnt),
    .odd_cnt  (odd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks {in_ready, busy, done} and both counters in one go.
  task automatic chk_all(input string tag, input logic [2:0] flags,
                         input int ev, input int od);
    chk({tag, " flags"}, 64'({in_ready, busy, done}), 64'(flags));
    chk({tag, " even"}, 64'(even_cnt), 64'(ev));
    chk({tag, " odd"}, 64'(odd_cnt), 64'(od));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    in_valid   = 1'b0;
    in_data    = '0;

    // 1. Reset values, then idle with start low.
    repeat (3) tick();
    chk_all("reset", 3'b000, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("idle_after_reset", 3'b000, 0, 0);
    end

    // 2. Full-rate block: len=4, data 0,1,2,7.
    start = 1'b1; len = 16'd4;
    tick();
    start = 1'b0; len = 16'd0;
    chk_all("run_entry", 3'b110, 0, 0);
    in_valid = 1'b1;
    in_data = 32'd0; tick();
    chk_all("fr_beat1", 3'b110, 1, 0);
    in_data = 32'd1; tick();
    chk_all("fr_beat2", 3'b110, 1, 1);
    in_data = 32'd2; tick();
    chk_all("fr_beat3", 3'b110, 2, 1);
    in_data = 32'd7; tick();
    chk_all("fr_done", 3'b011, 2, 2);
    in_data = 32'd8; tick();
    chk_all("fr_idle", 3'b000, 2, 2);
    tick();
    chk_all("fr_no_extra", 3'b000, 2, 2);
    in_valid = 1'b0;

    // 3. Bubbles: len=3, 2-cycle gaps between beats.
    start = 1'b1; len = 16'd3;
    tick();
    start = 1'b0;
    chk_all("bub_entry", 3'b110, 0, 0);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
    in_valid = 1'b0; in_data = 32'd4;
    chk_all("bub_beat1", 3'b110, 0, 1);
    tick(); tick();
    chk_all("bub_gap1", 3'b110, 0, 1);
    in_valid = 1'b1; in_data = 32'h8000_0000; tick();
    in_valid = 1'b0; in_data = 32'd9;
    chk_all("bub_beat2", 3'b110, 1, 1);
    tick(); tick();
    chk_all("bub_gap2", 3'b110, 1, 1);
    in_valid = 1'b1; in_data = 32'd5; tick();
    in_valid = 1'b0;
    chk_all("bub_done", 3'b011, 1, 2);
    tick();
    chk_all("bub_idle", 3'b000, 1, 2);

    // 4. Zero length block.
    start = 1'b1; len = 16'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd3;
    chk_all("zero_done", 3'b011, 0, 0);
    tick();
    chk_all("zero_idle", 3'b000, 0, 0);
    in_valid = 1'b0;

    // 5. Mid-block asynchronous reset, then a fresh len=1 block.
    start = 1'b1; len = 16'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd1; tick();
    in_data = 32'd2; tick();
    chk_all("mid_partial", 3'b110, 1, 1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_async_reset", 3'b000, 0, 0);
    tick();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("mid_no_done", 3'b000, 0, 0);
    end
    start = 1'b1; len = 16'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd6; tick();
    in_valid = 1'b0;
    chk_all("post_reset_done", 3'b011, 1, 0);
    tick();

    // 6. Ignored start during RUN, then back-to-back blocks.
    start = 1'b1; len = 16'd2;
    tick();
    start = 1'b1; len = 16'd7;
    in_valid = 1'b1; in_data = 32'd3; tick();
    start = 1'b0; len = 16'd0;
    chk_all("b2b_a_beat1", 3'b110, 0, 1);
    tick();
    in_valid = 1'b0;
    chk_all("b2b_a_done", 3'b011, 0, 2);
    tick();
    chk_all("b2b_gap_idle", 3'b000, 0, 2);
    start = 1'b1; len = 16'd1;
    tick();
    start = 1'b0;
    chk_all("b2b_b_entry", 3'b110, 0, 0);
    in_valid = 1'b1; in_data = 32'd10; tick();
    in_valid = 1'b0;
    chk_all("b2b_b_done", 3'b011, 1, 0);
    tick();
    chk_all("b2b_b_idle", 3'b000, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
